// File: rtl/spi_eeprom_arbiter.sv
// Round-robin arbiter sharing one SPI EEPROM master among four requesters,
// with a per-device write-cycle hold-off timer after each completed write.
module spi_eeprom_arbiter #(
    parameter int TWC_CYCLES  = 250000,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [3:0]  req_rd_wr,
    input  logic [35:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [7:0]  req_sel,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic        err,
    output logic [7:0]  rd_data,
    output logic [3:0]  wc_busy,
    output logic        m_start,
    output logic        m_rd_wr,
    output logic [8:0]  m_addr,
    output logic [7:0]  m_data_in,
    output logic [1:0]  m_eeprom_sel,
    input  logic        m_busy,
    input  logic [7:0]  m_data_out
);

    localparam int CW = (TWC_CYCLES > 0) ? $clog2(TWC_CYCLES + 1) : 1;
    localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TWC_LOAD = CW'(TWC_CYCLES);
    localparam logic [AW-1:0] ACK_LAST = AW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        COMPLETE
    } state_t;

    state_t        state;
    logic [1:0]    ptr;
    logic [1:0]    owner;
    logic          err_r;
    logic [AW-1:0] ack_cnt;
    logic [CW-1:0] wc_cnt [4];

    logic [3:0]    elig;
    logic          found;
    logic [1:0]    win;
    logic [1:0]    idx;

    // Eligibility uses this cycle's counter, so a device frees up the
    // same cycle its counter reads zero.
    always_comb begin
        elig  = '0;
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int i = 0; i < 4; i++) begin
            elig[i] = req[i] && (wc_cnt[req_sel[2*i +: 2]] == '0);
        end
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        wc_busy = '0;
        for (int d = 0; d < 4; d++) begin
            wc_busy[d] = (wc_cnt[d] != '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            owner        <= '0;
            err_r        <= 1'b0;
            ack_cnt      <= '0;
            gnt          <= '0;
            done         <= '0;
            err          <= 1'b0;
            rd_data      <= '0;
            m_start      <= 1'b0;
            m_rd_wr      <= 1'b0;
            m_addr       <= '0;
            m_data_in    <= '0;
            m_eeprom_sel <= '0;
            for (int d = 0; d < 4; d++) begin
                wc_cnt[d] <= '0;
            end
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (wc_cnt[d] != '0) begin
                    wc_cnt[d] <= wc_cnt[d] - 1'b1;
                end
            end
            done    <= '0;
            err     <= 1'b0;
            m_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        owner        <= win;
                        gnt          <= 4'b0001 << win;
                        m_rd_wr      <= req_rd_wr[win];
                        m_addr       <= req_addr[9*win +: 9];
                        m_data_in    <= req_data[8*win +: 8];
                        m_eeprom_sel <= req_sel[2*win +: 2];
                        m_start      <= 1'b1;
                        err_r        <= 1'b0;
                        ack_cnt      <= '0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT_ACK;
                WAIT_ACK: begin
                    if (m_busy) begin
                        state <= WAIT_DONE;
                    end else if (ack_cnt == ACK_LAST) begin
                        err_r <= 1'b1;
                        err   <= 1'b1;
                        done  <= 4'b0001 << owner;
                        state <= COMPLETE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!m_busy) begin
                        if (m_rd_wr) begin
                            rd_data <= m_data_out;
                        end
                        done  <= 4'b0001 << owner;
                        state <= COMPLETE;
                    end
                end
                COMPLETE: begin
                    // Placed after the decrement loop so the load wins.
                    if (!m_rd_wr && !err_r) begin
                        wc_cnt[m_eeprom_sel] <= TWC_LOAD;
                    end
                    gnt   <= '0;
                    ptr   <= owner + 2'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_eeprom_arbiter.sv
// Directed bench for spi_eeprom_arbiter with a small SPI master model.
module tb_spi_eeprom_arbiter;

    localparam int TWC = 20;
    localparam int ACK = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  req_rd_wr;
    logic [35:0] req_addr;
    logic [31:0] req_data;
    logic [7:0]  req_sel;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        err;
    logic [7:0]  rd_data;
    logic [3:0]  wc_busy;
    logic        m_start;
    logic        m_rd_wr;
    logic [8:0]  m_addr;
    logic [7:0]  m_data_in;
    logic [1:0]  m_eeprom_sel;
    logic        m_busy;
    logic [7:0]  m_data_out;

    int checks = 0;
    int errors = 0;
    bit ack_en = 1'b1;
    int busy_len = 1;
    logic [7:0] rdv = 8'h00;
    int start_cnt = 0;
    int done_cnt = 0;

    spi_eeprom_arbiter #(.TWC_CYCLES(TWC), .ACK_TIMEOUT(ACK)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rd_wr(req_rd_wr),
        .req_addr(req_addr), .req_data(req_data), .req_sel(req_sel),
        .gnt(gnt), .done(done), .err(err), .rd_data(rd_data),
        .wc_busy(wc_busy), .m_start(m_start), .m_rd_wr(m_rd_wr),
        .m_addr(m_addr), .m_data_in(m_data_in),
        .m_eeprom_sel(m_eeprom_sel), .m_busy(m_busy),
        .m_data_out(m_data_out)
    );

    always #5 clk = ~clk;

    // Master model: busy rises one cycle after the start strobe.
    initial begin
        m_busy = 1'b0;
        m_data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (m_start && ack_en) begin
                @(negedge clk);
                m_busy = 1'b1;
                m_data_out = rdv;
                repeat (busy_len) @(negedge clk);
                m_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_start) start_cnt++;
        if (done != 4'b0) done_cnt++;
    end

    task automatic set_req(input int i, input bit rd, input logic [8:0] a,
                           input logic [7:0] d, input logic [1:0] s);
        req_rd_wr[i] = rd;
        req_addr[9*i +: 9] = a;
        req_data[8*i +: 8] = d;
        req_sel[2*i +: 2] = s;
        req[i] = 1'b1;
    endtask

    task automatic wait_start(input int budget, output int n, output bit ok);
        ok = 1'b0;
        n = 0;
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            if (m_start) ok = 1'b1;
        end
    endtask

    task automatic wait_done(input int budget, output int n, output bit ok);
        ok = 1'b0;
        n = 0;
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            if (done != 4'b0) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({gnt, done, err, m_start} !== 10'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b exp 0", {gnt, done, err, m_start});
        end
        checks++;
        if ({rd_data, m_addr, m_data_in, m_eeprom_sel, m_rd_wr, wc_busy} !== 32'b0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0",
                     {rd_data, m_addr, m_data_in, m_eeprom_sel, m_rd_wr, wc_busy});
        end
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        int n;
        bit ok;
        busy_len = 10;
        rdv = 8'h3C;
        start_cnt = 0;
        set_req(2, 1'b1, 9'h1A5, 8'h00, 2'd1);
        wait_done(60, n, ok);
        checks++;
        if (!ok || done !== 4'b0100) begin
            errors++;
            $display("FAIL rd_done got %b exp 0100", done);
        end
        checks++;
        if (rd_data !== 8'h3C || err !== 1'b0) begin
            errors++;
            $display("FAIL rd_data got %h/%b exp 3c/0", rd_data, err);
        end
        checks++;
        if (m_addr !== 9'h1A5 || m_eeprom_sel !== 2'd1) begin
            errors++;
            $display("FAIL rd_ops got %h/%0d exp 1a5/1", m_addr, m_eeprom_sel);
        end
        req[2] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (start_cnt !== 1 || gnt !== 4'b0) begin
            errors++;
            $display("FAIL rd_starts got %0d/%b exp 1/0000", start_cnt, gnt);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] gq [5];
        logic [3:0] exp_g [5];
        int ng = 0;
        int nd = 0;
        int cnt = 0;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        for (int i = 0; i < 5; i++) gq[i] = 4'b0;
        do_reset();
        busy_len = 1;
        start_cnt = 0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 9'(i), 8'h00, 2'(i));
        while (nd < 5 && cnt < 300) begin
            @(negedge clk);
            cnt++;
            if (m_start && ng < 5) begin
                gq[ng] = gnt;
                ng++;
            end
            if (done != 4'b0) begin
                nd++;
                if (nd == 5) req = 4'b0;
            end
        end
        req = 4'b0;
        checks++;
        if (nd != 5) begin
            errors++;
            $display("FAIL rr_timeout got %0d dones exp 5", nd);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (gq[i] !== exp_g[i]) begin
                errors++;
                $display("FAIL rr_grant%0d got %b exp %b", i, gq[i], exp_g[i]);
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (start_cnt !== 5) begin
            errors++;
            $display("FAIL rr_starts got %0d exp 5", start_cnt);
        end
    endtask

    task automatic test_twc_holdoff();
        int n;
        bit ok;
        busy_len = 1;
        set_req(0, 1'b0, 9'h010, 8'hA5, 2'd0);
        wait_done(40, n, ok);
        checks++;
        if (!ok || done !== 4'b0001 || m_data_in !== 8'hA5 || m_rd_wr !== 1'b0) begin
            errors++;
            $display("FAIL wr_done got %b/%h/%b exp 0001/a5/0", done, m_data_in, m_rd_wr);
        end
        req[0] = 1'b0;
        set_req(1, 1'b1, 9'h011, 8'h00, 2'd0);
        repeat (10) @(negedge clk);
        checks++;
        if (wc_busy !== 4'b0001 || gnt !== 4'b0) begin
            errors++;
            $display("FAIL twc_hold got %b/%b exp 0001/0000", wc_busy, gnt);
        end
        wait_start(40, n, ok);
        checks++;
        if (!ok || n != 12) begin
            errors++;
            $display("FAIL twc_start got %0d exp 12", n);
        end
        checks++;
        if (wc_busy !== 4'b0 || gnt !== 4'b0010) begin
            errors++;
            $display("FAIL twc_free got %b/%b exp 0000/0010", wc_busy, gnt);
        end
        wait_done(40, n, ok);
        checks++;
        if (!ok || done !== 4'b0010) begin
            errors++;
            $display("FAIL twc_rd_done got %b exp 0010", done);
        end
        req[1] = 1'b0;
    endtask

    task automatic test_parallel();
        int n;
        bit ok;
        set_req(0, 1'b0, 9'h020, 8'h5A, 2'd0);
        wait_done(40, n, ok);
        checks++;
        if (!ok || done !== 4'b0001) begin
            errors++;
            $display("FAIL par_wr got %b exp 0001", done);
        end
        req[0] = 1'b0;
        rdv = 8'h77;
        set_req(2, 1'b1, 9'h120, 8'h00, 2'd2);
        wait_start(20, n, ok);
        checks++;
        if (!ok || n != 2) begin
            errors++;
            $display("FAIL par_start got %0d exp 2", n);
        end
        checks++;
        if (wc_busy !== 4'b0001 || gnt !== 4'b0100 || m_eeprom_sel !== 2'd2) begin
            errors++;
            $display("FAIL par_gnt got %b/%b/%0d exp 0001/0100/2", wc_busy, gnt, m_eeprom_sel);
        end
        req[2] = 1'b0;
        wait_done(40, n, ok);
        checks++;
        if (!ok || done !== 4'b0100 || rd_data !== 8'h77) begin
            errors++;
            $display("FAIL par_drop got %b/%h exp 0100/77", done, rd_data);
        end
        @(negedge clk);
        checks++;
        if (wc_busy !== 4'b0001) begin
            errors++;
            $display("FAIL rd_noload got %b exp 0001", wc_busy);
        end
    endtask

    task automatic test_ack_timeout();
        int n;
        bit ok;
        repeat (25) @(negedge clk);
        ack_en = 1'b0;
        set_req(3, 1'b0, 9'h1FF, 8'h3C, 2'd3);
        wait_start(20, n, ok);
        wait_done(40, n, ok);
        checks++;
        if (!ok || n != 9) begin
            errors++;
            $display("FAIL to_latency got %0d exp 9", n);
        end
        checks++;
        if (done !== 4'b1000 || err !== 1'b1) begin
            errors++;
            $display("FAIL to_err got %b/%b exp 1000/1", done, err);
        end
        req[3] = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || wc_busy !== 4'b0) begin
            errors++;
            $display("FAIL to_noload got %b/%b exp 0/0000", err, wc_busy);
        end
        ack_en = 1'b1;
    endtask

    task automatic test_reset_midop();
        int n;
        int dc;
        int cnt;
        bit ok;
        busy_len = 1;
        set_req(1, 1'b0, 9'h055, 8'h11, 2'd1);
        wait_done(40, n, ok);
        req[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (wc_busy !== 4'b0010) begin
            errors++;
            $display("FAIL mid_wc got %b exp 0010", wc_busy);
        end
        busy_len = 10;
        set_req(3, 1'b1, 9'h033, 8'h00, 2'd3);
        wait_start(20, n, ok);
        repeat (4) @(negedge clk);
        dc = done_cnt;
        reset = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0 || m_start !== 1'b0 || wc_busy !== 4'b0) begin
            errors++;
            $display("FAIL mid_reset got %b/%b/%b exp 0", gnt, m_start, wc_busy);
        end
        repeat (3) @(negedge clk);
        cnt = 0;
        while (m_busy && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (done_cnt !== dc) begin
            errors++;
            $display("FAIL mid_nodone got %0d exp %0d", done_cnt, dc);
        end
        reset = 1'b0;
        set_req(0, 1'b1, 9'h000, 8'h00, 2'd0);
        wait_start(20, n, ok);
        checks++;
        if (!ok || gnt !== 4'b0001) begin
            errors++;
            $display("FAIL post_gnt got %b exp 0001", gnt);
        end
        wait_done(40, n, ok);
        req[0] = 1'b0;
        wait_done(60, n, ok);
        checks++;
        if (!ok || done !== 4'b1000) begin
            errors++;
            $display("FAIL post_next got %b exp 1000", done);
        end
        req[3] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req = '0;
        req_rd_wr = '0;
        req_addr = '0;
        req_data = '0;
        req_sel = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_twc_holdoff();
        test_parallel();
        test_ack_timeout();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_eeprom_arbiter.md
Name: spi_eeprom_arbiter

Overview:
- Shares the single SPI EEPROM master among four requesters using round-robin arbitration.
- Sequences each granted transaction over the master's start/busy_flag handshake and returns read data plus a completion pulse.
- Enforces the EEPROM internal write-cycle time (tWC) per device: after a write, a device is not addressed again until its tWC timer expires. Other devices are served in the meantime.
- Sits between the system-side requesters and the master.

Parameters:
- TWC_CYCLES, 250000: clk cycles of write-cycle hold-off per device (5 ms at 50 MHz). 0 disables hold-off.
- ACK_TIMEOUT, 64: clk cycles allowed in WAIT_ACK for m_busy to rise before the transaction is aborted with error.

Ports:
- clk  input  1  50 MHz system clock; all block registers on rising edge.
- reset  input  1  asynchronous, active-high.
- req  input  4  per-requester request, level, held until own done pulse.
- req_rd_wr  input  4  per-requester direction: 1 = read, 0 = write.
- req_addr  input  36  per-requester byte address; requester i uses bits [9i+8:9i].
- req_data  input  32  per-requester write byte; requester i uses bits [8i+7:8i].
- req_sel  input  8  per-requester device select; requester i uses bits [2i+1:2i].
- gnt  output  4  one-hot grant, high from ISSUE through COMPLETE.
- done  output  4  one-cycle completion pulse to the owning requester.
- err  output  1  valid with done: 1 = ack timeout.
- rd_data  output  8  read byte, valid with done and held until the next done.
- wc_busy  output  4  per-device flag: tWC timer nonzero.
- m_start  output  1  start strobe to the master.
- m_rd_wr  output  1  direction to the master.
- m_addr  output  9  address to the master.
- m_data_in  output  8  write byte to the master.
- m_eeprom_sel  output  2  device select to the master.
- m_busy  input  1  master busy_flag.
- m_data_out  input  8  master read data.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer ptr = 0; all four tWC counters = 0; owner = 0.
- Eligibility:
  - eligible[i] = req[i] & (tWC counter of device req_sel[i] == 0).
  - The winner is the first eligible index scanning ptr, ptr+1, ... modulo 4.
- IDLE:
  - If any requester is eligible, register the winner's operands onto m_rd_wr, m_addr, m_data_in and m_eeprom_sel; set owner and gnt[owner]; go to ISSUE.
  - Otherwise stay in IDLE. m_busy is ignored.
- ISSUE: m_start = 1 for exactly this one cycle; go to WAIT_ACK.
- WAIT_ACK:
  - m_busy = 1: go to WAIT_DONE.
  - Otherwise the ack counter increments; at ACK_TIMEOUT, set err_r = 1 and go to COMPLETE.
- WAIT_DONE:
  - m_busy = 0: capture m_data_out into rd_data if reading; go to COMPLETE.
  - There is no timeout in this state.
- COMPLETE:
  - done[owner] = 1 and err = err_r, this cycle only.
  - If the transaction was a write and err_r = 0, load the tWC counter of the selected device with TWC_CYCLES.
  - ptr = owner + 1 (mod 4); gnt cleared; go to IDLE.
- Latency:
  - Request seen eligible at edge N: gnt and the m_* operands valid at N+1, with m_start high during cycle N+1.
  - Minimum request-to-done (busy_flag one cycle): 5 cycles.
- m_* operand outputs hold stable from ISSUE through COMPLETE.
- tWC counters:
  - Width clog2(TWC_CYCLES+1).
  - Each decrements by 1 per cycle, saturating at 0.
  - A load in COMPLETE overrides the decrement of that device in the same cycle.
  - wc_busy[d] = (counter d != 0).
- Boundary conditions:
  - Simultaneous requests: exactly one grant, chosen round-robin; no requester is starved while it holds req.
  - Requester drops req mid-transaction: the transaction still completes and done is still pulsed.
  - Requests are not re-sampled until IDLE. A request seen in IDLE during the COMPLETE→IDLE cycle is eligible immediately, so back-to-back transactions have one idle gap.
  - All requesters targeting held-off devices: the block stays in IDLE and grants when the counter reaches 0. Eligibility is evaluated against the counter value of the current cycle.
  - Read transactions never load tWC.
  - Aborted writes (err = 1) do not load tWC.
  - Reset mid-transaction: immediate return to the reset state, m_start deasserted, tWC counters cleared, no done pulse.

Test Plan:
- Single read: req[2] = 1, rd, addr 0x1A5, sel 1; master model asserts busy 10 cycles and returns 0x3C → one m_start pulse, m_addr = 0x1A5, m_eeprom_sel = 1, done[2] pulse, rd_data = 0x3C, err = 0.
- Round-robin fairness: req = 4'b1111, all reads to different devices, held → grant order 0, 1, 2, 3, 0; one m_start per grant.
- tWC hold-off (TWC_CYCLES = 20): requester 0 writes 0xA5 to dev 0, then requester 1 reads dev 0 → second m_start no earlier than 20 cycles after done[0]; wc_busy[0] high during the wait.
- Parallel devices (TWC_CYCLES = 20): write dev 0, then read dev 2 → dev 2 is granted on the next IDLE cycle while wc_busy[0] = 1.
- Ack timeout (ACK_TIMEOUT = 8): m_busy tied 0, write request → done pulse with err = 1 after 8 WAIT_ACK cycles; no tWC load.
- Reset mid-op: assert reset during WAIT_DONE → gnt = 0, m_start = 0, wc_busy = 0, no done; a request after reset is served with grant starting at index 0.
